// File: rtl/adma_dm_data_buf_wc.sv
// Source-to-destination data buffer: DEPTH-entry FIFO with up/down width conversion and last tracking.
// Define ADMA_DB_HWM_EN to add the occupancy high-water-mark port (hwm) and its clear input (hwm_clr).
module adma_dm_data_buf_wc #(
    parameter int SRC_W = 256,
    parameter int DST_W = 256,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [SRC_W-1:0] src_data,
    input  logic             src_last,
    input  logic             src_vld,
    output logic             src_rdy,
    output logic [DST_W-1:0] dst_data,
    output logic             dst_last,
    output logic             dst_vld,
    input  logic             dst_rdy,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty,
    output logic             full
`ifdef ADMA_DB_HWM_EN
    ,
    input  logic             hwm_clr,
    output logic [CNT_W-1:0] hwm
`endif
);

    localparam int BUF_W = (SRC_W > DST_W) ? SRC_W : DST_W;
    localparam int UP_R  = BUF_W / SRC_W;
    localparam int DN_R  = BUF_W / DST_W;
    localparam int PI_W  = (UP_R > 1) ? $clog2(UP_R) : 1;
    localparam int UI_W  = (DN_R > 1) ? $clog2(DN_R) : 1;
    localparam int AW    = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [PI_W-1:0]   pack_idx_q, pack_idx_d;
    logic [BUF_W-1:0]  pack_q, pack_d;
    logic [UI_W-1:0]   unpk_idx_q, unpk_idx_d;
    logic              ready_q, ready_d;

    logic [BUF_W-1:0]  mem_data_q [DEPTH];
    logic              mem_last_q [DEPTH];

    logic              empty_w, full_w;
    logic              src_hs, dst_hs;
    logic              pack_last_lane, unpk_last_slice;
    logic              push, pop;
    logic [BUF_W-1:0]  commit_word;
    logic [BUF_W-1:0]  rd_word;
    logic [DST_W-1:0]  rd_slice;

    assign empty_w   = (wr_ptr_q == rd_ptr_q);
    assign full_w    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign empty     = empty_w;
    assign full      = full_w;

    // ready_q keeps src_rdy low for as long as reset is held.
    assign src_rdy = ready_q & ~full_w & ~flush;
    assign dst_vld = ~empty_w;
    assign src_hs  = src_vld & src_rdy;
    assign dst_hs  = dst_vld & dst_rdy;

    assign pack_last_lane  = (pack_idx_q == PI_W'(UP_R - 1));
    assign unpk_last_slice = (unpk_idx_q == UI_W'(DN_R - 1));
    assign push            = src_hs & (src_last | pack_last_lane);
    assign pop             = dst_hs & unpk_last_slice;

    // Merge the incoming beat into its lane; lanes above it are still zero in the packer.
    always_comb begin
        commit_word = pack_q;
        for (int l = 0; l < UP_R; l++) begin
            if (pack_idx_q == PI_W'(l)) begin
                commit_word[l*SRC_W +: SRC_W] = src_data;
            end
        end
    end

    assign rd_word = mem_data_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        rd_slice = '0;
        for (int l = 0; l < DN_R; l++) begin
            if (unpk_idx_q == UI_W'(l)) begin
                rd_slice = rd_word[l*DST_W +: DST_W];
            end
        end
    end

    assign dst_data = dst_vld ? rd_slice : '0;
    assign dst_last = dst_vld & mem_last_q[rd_ptr_q[AW-1:0]] & unpk_last_slice;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pack_idx_d = pack_idx_q;
        pack_d     = pack_q;
        unpk_idx_d = unpk_idx_q;
        ready_d    = 1'b1;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pack_idx_d = '0;
            pack_d     = '0;
            unpk_idx_d = '0;
        end else begin
            if (src_hs) begin
                if (push) begin
                    pack_d     = '0;
                    pack_idx_d = '0;
                end else begin
                    pack_d     = commit_word;
                    pack_idx_d = pack_idx_q + 1'b1;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (dst_hs) begin
                unpk_idx_d = unpk_last_slice ? '0 : unpk_idx_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pack_idx_q <= '0;
            pack_q     <= '0;
            unpk_idx_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pack_idx_q <= pack_idx_d;
            pack_q     <= pack_d;
            unpk_idx_q <= unpk_idx_d;
            ready_q    <= ready_d;
        end
    end

    // Storage is not reset; dst outputs are masked until an entry is committed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= commit_word;
            mem_last_q[wr_ptr_q[AW-1:0]] <= src_last;
        end
    end

`ifdef ADMA_DB_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (hwm_clr) begin
            hwm_d = occupancy;
        end else if (occupancy > hwm_q) begin
            hwm_d = occupancy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_adma_dm_data_buf_wc.sv
// Directed bench for adma_dm_data_buf_wc: equal-width, upsize 64->256 and downsize 256->64 instances.
module tb_adma_dm_data_buf_wc;

    typedef struct {
        logic         src_vld;
        logic [255:0] src_data;
        logic         src_last;
        logic         dst_rdy;
        logic         flush;
        logic         exp_src_rdy;
        logic         exp_dst_vld;
        logic [255:0] exp_data;
        logic         exp_last;
        logic [2:0]   exp_occ;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic [255:0] eq_src_data = '0;
    logic         eq_src_last = 1'b0, eq_src_vld = 1'b0, eq_src_rdy;
    logic [255:0] eq_dst_data;
    logic         eq_dst_last, eq_dst_vld, eq_dst_rdy = 1'b0;
    logic [2:0]   eq_occ;
    logic         eq_empty, eq_full;

    logic [63:0]  up_src_data = '0;
    logic         up_src_last = 1'b0, up_src_vld = 1'b0, up_src_rdy;
    logic [255:0] up_dst_data;
    logic         up_dst_last, up_dst_vld, up_dst_rdy = 1'b0;
    logic [2:0]   up_occ;
    logic         up_empty, up_full;

    logic [255:0] dn_src_data = '0;
    logic         dn_src_last = 1'b0, dn_src_vld = 1'b0, dn_src_rdy;
    logic [63:0]  dn_dst_data;
    logic         dn_dst_last, dn_dst_vld, dn_dst_rdy = 1'b0;
    logic [2:0]   dn_occ;
    logic         dn_empty, dn_full;

`ifdef ADMA_DB_HWM_EN
    logic [2:0] eq_hwm, up_hwm, dn_hwm;
`endif

    int errors = 0;
    int checks = 0;
    vec_t vecs[28];

    always #5 clk = ~clk;

    adma_dm_data_buf_wc #(.SRC_W(256), .DST_W(256), .DEPTH(4)) u_eq (
`ifdef ADMA_DB_HWM_EN
        .hwm_clr(1'b0), .hwm(eq_hwm),
`endif
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_data(eq_src_data), .src_last(eq_src_last), .src_vld(eq_src_vld), .src_rdy(eq_src_rdy),
        .dst_data(eq_dst_data), .dst_last(eq_dst_last), .dst_vld(eq_dst_vld), .dst_rdy(eq_dst_rdy),
        .occupancy(eq_occ), .empty(eq_empty), .full(eq_full)
    );

    adma_dm_data_buf_wc #(.SRC_W(64), .DST_W(256), .DEPTH(4)) u_up (
`ifdef ADMA_DB_HWM_EN
        .hwm_clr(1'b0), .hwm(up_hwm),
`endif
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_data(up_src_data), .src_last(up_src_last), .src_vld(up_src_vld), .src_rdy(up_src_rdy),
        .dst_data(up_dst_data), .dst_last(up_dst_last), .dst_vld(up_dst_vld), .dst_rdy(up_dst_rdy),
        .occupancy(up_occ), .empty(up_empty), .full(up_full)
    );

    adma_dm_data_buf_wc #(.SRC_W(256), .DST_W(64), .DEPTH(4)) u_dn (
`ifdef ADMA_DB_HWM_EN
        .hwm_clr(1'b0), .hwm(dn_hwm),
`endif
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_data(dn_src_data), .src_last(dn_src_last), .src_vld(dn_src_vld), .src_rdy(dn_src_rdy),
        .dst_data(dn_dst_data), .dst_last(dn_dst_last), .dst_vld(dn_dst_vld), .dst_rdy(dn_dst_rdy),
        .occupancy(dn_occ), .empty(dn_empty), .full(dn_full)
    );

    function automatic vec_t mk(input logic sv, input logic [255:0] sd, input logic sl,
                                input logic dr, input logic fl, input logic ers, input logic edv,
                                input logic [255:0] ed, input logic el, input logic [2:0] eo);
        vec_t v;
        v.src_vld = sv; v.src_data = sd; v.src_last = sl; v.dst_rdy = dr; v.flush = fl;
        v.exp_src_rdy = ers; v.exp_dst_vld = edv; v.exp_data = ed; v.exp_last = el; v.exp_occ = eo;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        eq_src_vld  = v.src_vld;
        eq_src_data = v.src_data;
        eq_src_last = v.src_last;
        eq_dst_rdy  = v.dst_rdy;
        flush       = v.flush;
    endtask

    task automatic up_push(input logic [63:0] d, input logic l);
        up_src_vld = 1'b1; up_src_data = d; up_src_last = l;
        tick();
        up_src_vld = 1'b0; up_src_last = 1'b0;
    endtask

    initial begin
        // Equal width, DEPTH=4: fill to full, drain, push+pop together, wrap, flush.
        vecs[0]  = mk(1, 256'h1, 0, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[1]  = mk(1, 256'h2, 0, 0, 0, 1, 1, 256'h1, 0, 1);
        vecs[2]  = mk(1, 256'h3, 0, 0, 0, 1, 1, 256'h1, 0, 2);
        vecs[3]  = mk(1, 256'h4, 1, 0, 0, 1, 1, 256'h1, 0, 3);
        vecs[4]  = mk(0, 256'h0, 0, 0, 0, 0, 1, 256'h1, 0, 4);
        vecs[5]  = mk(0, 256'h0, 0, 1, 0, 0, 1, 256'h1, 0, 4);
        vecs[6]  = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h2, 0, 3);
        vecs[7]  = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h3, 0, 2);
        vecs[8]  = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h4, 1, 1);
        vecs[9]  = mk(1, 256'h5, 0, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[10] = mk(1, 256'h6, 0, 1, 0, 1, 1, 256'h5, 0, 1);
        vecs[11] = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h6, 0, 1);
        vecs[12] = mk(0, 256'h0, 0, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[13] = mk(1, 256'h7, 0, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[14] = mk(1, 256'h8, 0, 0, 0, 1, 1, 256'h7, 0, 1);
        vecs[15] = mk(1, 256'h9, 0, 0, 0, 1, 1, 256'h7, 0, 2);
        vecs[16] = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h7, 0, 3);
        vecs[17] = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h8, 0, 2);
        vecs[18] = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'h9, 0, 1);
        vecs[19] = mk(1, 256'hA, 0, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[20] = mk(1, 256'hB, 0, 0, 0, 1, 1, 256'hA, 0, 1);
        vecs[21] = mk(1, 256'hC, 0, 0, 0, 1, 1, 256'hA, 0, 2);
        vecs[22] = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'hA, 0, 3);
        vecs[23] = mk(1, 256'hD, 0, 1, 1, 0, 1, 256'hB, 0, 2);
        vecs[24] = mk(0, 256'h0, 0, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[25] = mk(1, 256'hE, 1, 0, 0, 1, 0, 256'h0, 0, 0);
        vecs[26] = mk(0, 256'h0, 0, 1, 0, 1, 1, 256'hE, 1, 1);
        vecs[27] = mk(0, 256'h0, 0, 0, 0, 1, 0, 256'h0, 0, 0);

        #12;
        checkOutput("rst_src_rdy", 256'(eq_src_rdy), 256'h0);
        checkOutput("rst_dst_vld", 256'(eq_dst_vld), 256'h0);
        checkOutput("rst_dst_last", 256'(eq_dst_last), 256'h0);
        checkOutput("rst_dst_data", eq_dst_data, 256'h0);
        checkOutput("rst_occ", 256'(eq_occ), 256'h0);
        checkOutput("rst_empty", 256'(eq_empty), 256'h1);
        checkOutput("rst_full", 256'(eq_full), 256'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("eq[%0d].src_rdy", i), 256'(eq_src_rdy), 256'(vecs[i].exp_src_rdy));
            checkOutput($sformatf("eq[%0d].dst_vld", i), 256'(eq_dst_vld), 256'(vecs[i].exp_dst_vld));
            checkOutput($sformatf("eq[%0d].dst_data", i), eq_dst_data, vecs[i].exp_data);
            checkOutput($sformatf("eq[%0d].dst_last", i), 256'(eq_dst_last), 256'(vecs[i].exp_last));
            checkOutput($sformatf("eq[%0d].occ", i), 256'(eq_occ), 256'(vecs[i].exp_occ));
            checkOutput($sformatf("eq[%0d].full", i), 256'(eq_full), 256'(vecs[i].exp_occ == 3'd4));
            checkOutput($sformatf("eq[%0d].empty", i), 256'(eq_empty), 256'(vecs[i].exp_occ == 3'd0));
            tick();
        end
        applyStimulus(mk(0, 256'h0, 0, 0, 0, 0, 0, 256'h0, 0, 0));

        // Upsize: full burst with last, packer excluded from occupancy.
        checkOutput("up_src_rdy", 256'(up_src_rdy), 256'h1);
        up_push(64'hA, 1'b0);
        up_push(64'hB, 1'b0);
        up_push(64'hC, 1'b0);
        checkOutput("up_occ_packing", 256'(up_occ), 256'h0);
        checkOutput("up_vld_packing", 256'(up_dst_vld), 256'h0);
        up_push(64'hD, 1'b1);
        checkOutput("up_occ_commit", 256'(up_occ), 256'h1);
        checkOutput("up_vld_commit", 256'(up_dst_vld), 256'h1);
        checkOutput("up_data_full", up_dst_data, {64'hD, 64'hC, 64'hB, 64'hA});
        checkOutput("up_last_full", 256'(up_dst_last), 256'h1);
        tick();
        checkOutput("up_data_stall", up_dst_data, {64'hD, 64'hC, 64'hB, 64'hA});
        up_dst_rdy = 1'b1;
        tick();
        up_dst_rdy = 1'b0;
        checkOutput("up_empty_pop", 256'(up_empty), 256'h1);

        // Upsize partial burst: unfilled lanes are zero.
        up_push(64'h11, 1'b0);
        up_push(64'h22, 1'b1);
        checkOutput("up_data_part", up_dst_data, {64'h0, 64'h0, 64'h22, 64'h11});
        checkOutput("up_last_part", 256'(up_dst_last), 256'h1);
        up_dst_rdy = 1'b1;
        tick();
        up_dst_rdy = 1'b0;

        // Upsize commit on the R-th beat without last.
        for (int k = 1; k <= 4; k++) up_push(64'(k), 1'b0);
        checkOutput("up_occ_r", 256'(up_occ), 256'h1);
        checkOutput("up_data_r", up_dst_data, {64'h4, 64'h3, 64'h2, 64'h1});
        checkOutput("up_last_r", 256'(up_dst_last), 256'h0);
        up_dst_rdy = 1'b1;
        tick();
        up_dst_rdy = 1'b0;
        checkOutput("up_empty_r", 256'(up_empty), 256'h1);

        // Downsize: one entry emerges as four slices, last only on slice 3.
        dn_src_vld = 1'b1; dn_src_data = {64'h4, 64'h3, 64'h2, 64'h1}; dn_src_last = 1'b1;
        tick();
        dn_src_vld = 1'b0; dn_src_last = 1'b0;
        checkOutput("dn_occ_push", 256'(dn_occ), 256'h1);
        tick();
        checkOutput("dn_data_stall", 256'(dn_dst_data), 256'h1);
        checkOutput("dn_last_stall", 256'(dn_dst_last), 256'h0);
        for (int k = 0; k < 4; k++) begin
            dn_dst_rdy = 1'b1;
            #1;
            checkOutput($sformatf("dn_vld[%0d]", k), 256'(dn_dst_vld), 256'h1);
            checkOutput($sformatf("dn_data[%0d]", k), 256'(dn_dst_data), 256'(k + 1));
            checkOutput($sformatf("dn_last[%0d]", k), 256'(dn_dst_last), 256'(k == 3));
            checkOutput($sformatf("dn_occ[%0d]", k), 256'(dn_occ), 256'h1);
            tick();
        end
        dn_dst_rdy = 1'b0;
        checkOutput("dn_occ_done", 256'(dn_occ), 256'h0);
        checkOutput("dn_vld_done", 256'(dn_dst_vld), 256'h0);

        // Async reset mid-burst: eq holds 2 entries, up holds a partial packer.
        eq_src_vld = 1'b1; eq_src_data = 256'h21; up_src_vld = 1'b1; up_src_data = 64'h99;
        tick();
        eq_src_data = 256'h22; up_src_vld = 1'b0;
        tick();
        eq_src_vld = 1'b0;
        checkOutput("ar_occ_before", 256'(eq_occ), 256'h2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_dst_vld", 256'(eq_dst_vld), 256'h0);
        checkOutput("ar_occ", 256'(eq_occ), 256'h0);
        checkOutput("ar_empty", 256'(eq_empty), 256'h1);
        checkOutput("ar_src_rdy", 256'(eq_src_rdy), 256'h0);
        checkOutput("ar_dst_data", eq_dst_data, 256'h0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        checkOutput("ar_src_rdy_rel", 256'(eq_src_rdy), 256'h1);
        checkOutput("ar_up_src_rdy_rel", 256'(up_src_rdy), 256'h1);
        up_push(64'h55, 1'b1);
        checkOutput("ar_up_data", up_dst_data, {64'h0, 64'h0, 64'h0, 64'h55});
        checkOutput("ar_up_last", 256'(up_dst_last), 256'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
